// File: rtl/uart_rx_loader.sv
// UART receiver that writes each received word into RAM at an auto-incrementing pointer.
// Optional even-parity checking is compiled in with `define UART_RX_LOADER_PARITY_EN.
module uart_rx_loader #(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  rst_l,
  input  logic                  rx,
  input  logic                  ptr_clr,
  output logic                  wr,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  frame_err,
  output logic                  wrapped,
  output logic                  parity_err
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IdxW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CntW-1:0] HalfBit = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] FullBit = CntW'(CLKS_PER_BIT - 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StWrite,
    StRecover
  } state_e;

  state_e                state_q, state_d;
  logic                  rx_meta_q, rx_s_q;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic                  frame_err_q, frame_err_d;
  logic                  wrapped_q, wrapped_d;
  logic                  cnt_zero;
  logic                  par_ok;

  assign cnt_zero = (cnt_q == '0);

`ifdef UART_RX_LOADER_PARITY_EN
  logic par_err_q, par_err_d;
  logic par_bad_q, par_bad_d;

  assign par_ok     = ~par_bad_q;
  assign parity_err = par_err_q;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      par_err_q <= 1'b0;
      par_bad_q <= 1'b0;
    end else begin
      par_err_q <= par_err_d;
      par_bad_q <= par_bad_d;
    end
  end
`else
  assign par_ok     = 1'b1;
  assign parity_err = 1'b0;
`endif

  // Synchronizer idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      idx_q       <= '0;
      shreg_q     <= '0;
      wdata_q     <= '0;
      ptr_q       <= '0;
      frame_err_q <= 1'b0;
      wrapped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      wdata_q     <= wdata_d;
      ptr_q       <= ptr_d;
      frame_err_q <= frame_err_d;
      wrapped_q   <= wrapped_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shreg_d     = shreg_q;
    wdata_d     = wdata_q;
    frame_err_d = frame_err_q;
`ifdef UART_RX_LOADER_PARITY_EN
    par_err_d   = par_err_q;
    par_bad_d   = par_bad_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (!rx_s_q) begin
          state_d = StStart;
          cnt_d   = HalfBit;
        end
      end
      StStart: begin
        if (cnt_zero) begin
          if (rx_s_q) begin
            state_d = StIdle;
          end else begin
            state_d = StData;
            cnt_d   = FullBit;
            idx_d   = '0;
`ifdef UART_RX_LOADER_PARITY_EN
            par_bad_d = 1'b0;
`endif
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StData: begin
        if (cnt_zero) begin
          shreg_d = {rx_s_q, shreg_q[DATA_WIDTH-1:1]};
          cnt_d   = FullBit;
          idx_d   = idx_q + 1'b1;
          if (idx_q == LastIdx) begin
`ifdef UART_RX_LOADER_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StParity: begin
`ifdef UART_RX_LOADER_PARITY_EN
        if (cnt_zero) begin
          // Even parity: data plus parity bit must hold an even number of ones.
          par_bad_d = rx_s_q ^ (^shreg_q);
          if (rx_s_q ^ (^shreg_q)) par_err_d = 1'b1;
          state_d = StStop;
          cnt_d   = FullBit;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
`else
        state_d = StIdle;
`endif
      end
      StStop: begin
        if (cnt_zero) begin
          if (!rx_s_q) begin
            frame_err_d = 1'b1;
            state_d     = StRecover;
          end else if (par_ok) begin
            state_d = StWrite;
            wdata_d = shreg_q;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StWrite: state_d = StIdle;
      // Hold off until the line returns high so a break cannot retrigger START.
      StRecover: begin
        if (rx_s_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // ptr_clr wins over the post-write increment; the write itself uses the old pointer.
  always_comb begin
    ptr_d     = ptr_q;
    wrapped_d = wrapped_q;
    if (ptr_clr) begin
      ptr_d     = '0;
      wrapped_d = 1'b0;
    end else if (state_q == StWrite) begin
      ptr_d = ptr_q + 1'b1;
      if (ptr_q == '1) wrapped_d = 1'b1;
    end
  end

  assign wr        = (state_q == StWrite);
  assign addr      = ptr_q;
  assign wdata     = wdata_q;
  assign busy      = (state_q != StIdle);
  assign frame_err = frame_err_q;
  assign wrapped   = wrapped_q;

endmodule

// File: doc/uart_rx_loader.md
# uart_rx_loader

Serial UART receiver that deserializes frames arriving on a single `rx` line and writes each received word into the integration-test RAM through that RAM's `wr`/`addr`/`wdata` port. It is the stage directly upstream of the RAM. It owns an auto-incrementing write pointer, so a host can stream an image into memory byte-by-byte. Framing and overflow status are exposed for the testbench and SST probes.

## Interface
- `ADDR_WIDTH`, 8, RAM address width; write pointer width.
- `DATA_WIDTH`, 8, data bits per UART frame; RAM word width.
- `CLKS_PER_BIT`, 16, clock cycles per UART bit; must be an even number ≥ 4.

Ports:
- `clk`  in  1  sole clock; all state on posedge.
- `rst_l`  in  1  asynchronous, active-low reset.
- `rx`  in  1  serial input; idle high; asynchronous to `clk`.
- `ptr_clr`  in  1  synchronous pulse that returns the write pointer to 0.
- `wr`  out  1  RAM write strobe, one cycle per accepted word.
- `addr`  out  ADDR_WIDTH  RAM address; equals the write pointer.
- `wdata`  out  DATA_WIDTH  received word; valid while `wr`=1.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `frame_err`  out  1  sticky; set when the stop bit is sampled low.
- `wrapped`  out  1  sticky; set when the pointer wraps from 2^ADDR_WIDTH-1 to 0.
- `parity_err`  out  1  sticky parity-mismatch flag (see Configuration).

## Operation
- `rx` passes through a 2-flop synchronizer; the FSM sees only the synchronized `rx_s`.
- FSM states: IDLE, START, DATA, (PARITY), STOP, WRITE, RECOVER.
- IDLE → START on `rx_s`=0. The bit counter loads CLKS_PER_BIT/2-1.
- START: at mid-bit, if `rx_s`=0, go to DATA and reload the counter to CLKS_PER_BIT-1. If `rx_s`=1 (glitch), return to IDLE with no flags set.
- DATA: sample at each mid-bit, DATA_WIDTH samples total, LSB first, shifted into `shreg`. After the last sample, go to PARITY if compiled in, otherwise STOP.
- STOP: sample one bit period later.
  - Stop bit high and no parity error → WRITE.
  - Stop bit low → set `frame_err`, drop the word, go to RECOVER.
- WRITE: lasts exactly one cycle.
  - `wr`=1, `wdata`=`shreg`, `addr`=current pointer.
  - Next cycle the pointer increments modulo 2^ADDR_WIDTH. On the 2^ADDR_WIDTH-1 → 0 transition, set `wrapped`.
  - Then → IDLE.
- RECOVER: wait for `rx_s`=1, then → IDLE. This prevents a break condition from retriggering START.
- `ptr_clr`:
  - Sets the pointer to 0 on the next edge.
  - If it coincides with WRITE, the write still uses the old pointer, and the pointer becomes 0 rather than old+1.
  - Clears `wrapped`. It does not clear `frame_err` or `parity_err`.
- Sticky flags clear only on reset.

## Timing
- Reset values: `wr`=0, `addr`=0, `wdata`=0, `busy`=0, `frame_err`=0, `wrapped`=0, `parity_err`=0, FSM=IDLE, synchronizer flops=1.
- Reset asserted mid-frame aborts the frame immediately; no partial write occurs.
- Latency: `wr` rises 1 cycle after the stop-bit mid-sample. The mid-sample occurs (1.5 + DATA_WIDTH [+1 with parity]) bit periods plus 2 synchronizer cycles after the start-bit falling edge on `rx`.
- `wr` is never high for two consecutive cycles. Minimum gap between writes is one full frame.
- `addr` and `wdata` are registered and stable throughout the `wr` cycle. `wdata` holds its last value otherwise.
- A back-to-back frame whose start edge arrives in the WRITE cycle is detected in the following IDLE cycle. A late start of up to 1 cycle is tolerated within the mid-bit margin.

## Configuration
- `UART_RX_LOADER_PARITY_EN`
  - Defined: a PARITY state follows DATA and samples one even-parity bit. A mismatch sets `parity_err` and drops the word (no WRITE). STOP is still sampled and `frame_err` is still checked.
  - Undefined: no PARITY state, frame is start + DATA_WIDTH + stop, and `parity_err` is tied to 0.

## Test plan
- Reset, then send byte 0xA5 at CLKS_PER_BIT=16 → one `wr` pulse with `addr`=0x00, `wdata`=0xA5; pointer becomes 0x01; all flags 0.
- Stream 0x01, 0x02, 0x03 back-to-back → writes at addr 0, 1, 2 with matching data; exactly 3 `wr` cycles.
- Drive a 4-cycle low glitch on `rx` → FSM returns to IDLE; no `wr`; `frame_err`=0.
- Send 0x3C with the stop bit held low for 3 bit periods → `frame_err`=1, no `wr`, pointer unchanged. A following 0x55 is written at the unchanged pointer.
- With ADDR_WIDTH=2, send 5 bytes → addr sequence 0, 1, 2, 3, 0; `wrapped`=1 after the 4th write. Pulse `ptr_clr` during the 5th WRITE → the write goes to addr 0, `wrapped` clears, and the next write is also at addr 0.
- With the macro defined, send 0x07 with parity bit 0 (wrong) → `parity_err`=1, no write. Then send 0x07 with parity 1 → written; `parity_err` stays 1. Assert `rst_l` low mid-frame → all outputs at their reset values and no write.
